stopwatch_lcd_formatter: RTL and testbench

//  Consumer end of the StopwatchController display interface: watches sw_update_toggle/sw_lcd_mode,

---
 rtl/sw_lcd_pkg.sv | 54 +++++
 rtl/bcd_time_to_ascii.sv | 22 ++
 rtl/stopwatch_lcd_formatter.sv | 233 +++++++++++++++++++++++
 tb/tb_stopwatch_lcd_formatter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_lcd_pkg.sv
// Shared encodings, ASCII constants and label table for the stopwatch LCD formatter.
package sw_lcd_pkg;

  typedef enum logic [1:0] {
    ModeRun  = 2'd0,
    ModeLap  = 2'd1,
    ModeStat = 2'd2,
    ModeRsvd = 2'd3
  } lcd_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } fmt_state_e;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiColon = 8'h3A;
  localparam logic [7:0] AsciiDot   = 8'h2E;
  localparam logic [7:0] AsciiDash  = 8'h2D;
  localparam logic [7:0] AsciiQmark = 8'h3F;
  localparam logic [7:0] AsciiZero  = 8'h30;

  localparam logic [31:0] LblCur  = "CUR ";
  localparam logic [31:0] LblLap  = "LAP ";
  localparam logic [31:0] LblInt  = "INT ";
  localparam logic [31:0] LblBest = "BEST";
  localparam logic [31:0] LblAvg  = "AVG ";

  // Reserved mode renders exactly like RUN.
  function automatic logic [7:0] label_char(lcd_mode_e mode, logic row, logic [1:0] pos);
    logic [31:0] lbl;
    case (mode)
      ModeLap:  lbl = row ? LblInt : LblLap;
      ModeStat: lbl = row ? LblAvg : LblBest;
      default:  lbl = row ? LblLap : LblCur;
    endcase
    case (pos)
      2'd0:    return lbl[31:24];
      2'd1:    return lbl[23:16];
      2'd2:    return lbl[15:8];
      default: return lbl[7:0];
    endcase
  endfunction

  // Non-decimal nibbles show as '?' so corrupt counters are visible on the glass.
  function automatic logic [7:0] digit_char(logic [3:0] d, logic valid);
    if (!valid) return AsciiDash;
    if (d <= 4'd9) return AsciiZero + {4'h0, d};
    return AsciiQmark;
  endfunction

endpackage

// File: rtl/bcd_time_to_ascii.sv
// Renders a packed BCD time {mt,mo,st,so,ct,co} as the 8 characters "MM:SS.CC".
module bcd_time_to_ascii
  import sw_lcd_pkg::*;
(
  input  logic [23:0] bcd,
  input  logic        valid,
  output logic [7:0]  text [8]
);

  // Fixed separators, digits dashed out when the time is not valid.
  always_comb begin
    text[0] = digit_char(bcd[23:20], valid);
    text[1] = digit_char(bcd[19:16], valid);
    text[2] = AsciiColon;
    text[3] = digit_char(bcd[15:12], valid);
    text[4] = digit_char(bcd[11:8], valid);
    text[5] = AsciiDot;
    text[6] = digit_char(bcd[7:4], valid);
    text[7] = digit_char(bcd[3:0], valid);
  end

endmodule

// File: rtl/stopwatch_lcd_formatter.sv
// Snapshots the selected stopwatch times on request and streams a 2x16 ASCII frame,
// one character per valid/ready transfer.
module stopwatch_lcd_formatter
  import sw_lcd_pkg::*;
#(
  parameter int unsigned COLS = 16,
  parameter int unsigned ROWS = 2
) (
  input  logic        clk_1k,
  input  logic        rst_n,
  input  logic        stopwatch_sw,
  input  logic [1:0]  sw_lcd_mode,
  input  logic        sw_update_toggle,
  input  logic        lap_valid,
  input  logic [23:0] cur_bcd,
  input  logic [23:0] lap_bcd,
  input  logic [23:0] int_bcd,
  input  logic [23:0] best_bcd,
  input  logic [23:0] avg_bcd,
  input  logic        char_ready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        char_row,
  output logic [3:0]  char_col,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [4:0] LastIdx = 5'(COLS * ROWS - 1);

  fmt_state_e  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        toggle_q, sw_q, pending_q, pending_d;
  logic        valid_d, busy_d, done_d, row_d;
  logic [7:0]  data_d;
  logic [3:0]  col_d;

  lcd_mode_e   snap_mode_q;
  logic        snap_lv_q;
  logic [23:0] snap_cur_q, snap_lap_q, snap_int_q, snap_best_q, snap_avg_q;

  lcd_mode_e   src_mode;
  logic        src_lv, load, req, xfer;
  logic [23:0] src_cur, src_lap, src_int, src_best, src_avg;
  logic [23:0] time0, time1;
  logic        tv0, tv1;
  logic [7:0]  text0 [8];
  logic [7:0]  text1 [8];
  logic [4:0]  nidx;
  logic        nrow;
  logic [3:0]  ncol;
  logic [2:0]  tpos;
  logic [7:0]  ch;

  assign load = (state_q == StLoad);
  assign req  = stopwatch_sw & ((sw_update_toggle != toggle_q) | ~sw_q);
  assign xfer = char_valid & char_ready;

  // In LOAD the first char is built from the live inputs being captured, afterwards from the snapshot.
  always_comb begin
    src_mode = load ? lcd_mode_e'(sw_lcd_mode) : snap_mode_q;
    src_lv   = load ? lap_valid : snap_lv_q;
    src_cur  = load ? cur_bcd   : snap_cur_q;
    src_lap  = load ? lap_bcd   : snap_lap_q;
    src_int  = load ? int_bcd   : snap_int_q;
    src_best = load ? best_bcd  : snap_best_q;
    src_avg  = load ? avg_bcd   : snap_avg_q;
  end

  // Pick the time shown on each row for the selected mode.
  always_comb begin
    case (src_mode)
      ModeLap: begin
        time0 = src_lap;  tv0 = src_lv;
        time1 = src_int;  tv1 = src_lv;
      end
      ModeStat: begin
        time0 = src_best; tv0 = src_lv;
        time1 = src_avg;  tv1 = src_lv;
      end
      default: begin
        time0 = src_cur;  tv0 = 1'b1;
        time1 = src_lap;  tv1 = src_lv;
      end
    endcase
  end

  bcd_time_to_ascii u_row0_time (
    .bcd   (time0),
    .valid (tv0),
    .text  (text0)
  );

  bcd_time_to_ascii u_row1_time (
    .bcd   (time1),
    .valid (tv1),
    .text  (text1)
  );

  // Character for the index about to be presented: label, gap, time, gap.
  always_comb begin
    nidx = load ? 5'd0 : idx_q + 5'd1;
    nrow = nidx[4];
    ncol = nidx[3:0];
    tpos = 3'(ncol - 4'd6);
    if (ncol < 4'd4) begin
      ch = label_char(src_mode, nrow, ncol[1:0]);
    end else if (ncol >= 4'd6 && ncol <= 4'd13) begin
      ch = nrow ? text1[tpos] : text0[tpos];
    end else begin
      ch = AsciiSpace;
    end
  end

  // Frame sequencing; all outputs are registered from these next-state values.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    data_d    = char_data;
    row_d     = char_row;
    col_d     = char_col;
    if (req && state_q != StIdle) pending_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLoad;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        if (!stopwatch_sw) begin
          state_d   = StIdle;
          pending_d = 1'b0;
        end else begin
          state_d = StSend;
          idx_d   = 5'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = ch;
          row_d   = nrow;
          col_d   = ncol;
        end
      end
      StSend: begin
        if (!stopwatch_sw) begin
          // Never retract an offered char: finish the handshake, then drop the frame.
          if (xfer || !char_valid) begin
            state_d   = StIdle;
            pending_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end else if (xfer) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            idx_d   = nidx;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            data_d  = ch;
            row_d   = nrow;
            col_d   = ncol;
          end
        end else begin
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StDone: begin
        pending_d = 1'b0;
        if (stopwatch_sw && (pending_q || req)) begin
          state_d = StLoad;
          busy_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, edge-detect history, snapshot and output registers.
  always_ff @(posedge clk_1k) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= 5'd0;
      toggle_q    <= 1'b0;
      sw_q        <= 1'b0;
      pending_q   <= 1'b0;
      char_valid  <= 1'b0;
      char_data   <= AsciiSpace;
      char_row    <= 1'b0;
      char_col    <= 4'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      snap_mode_q <= ModeRun;
      snap_lv_q   <= 1'b0;
      snap_cur_q  <= 24'd0;
      snap_lap_q  <= 24'd0;
      snap_int_q  <= 24'd0;
      snap_best_q <= 24'd0;
      snap_avg_q  <= 24'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      toggle_q   <= sw_update_toggle;
      sw_q       <= stopwatch_sw;
      pending_q  <= pending_d;
      char_valid <= valid_d;
      char_data  <= data_d;
      char_row   <= row_d;
      char_col   <= col_d;
      busy       <= busy_d;
      frame_done <= done_d;
      if (load) begin
        snap_mode_q <= lcd_mode_e'(sw_lcd_mode);
        snap_lv_q   <= lap_valid;
        snap_cur_q  <= cur_bcd;
        snap_lap_q  <= lap_bcd;
        snap_int_q  <= int_bcd;
        snap_best_q <= best_bcd;
        snap_avg_q  <= avg_bcd;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_lcd_formatter.sv
// Scoreboard bench: expected frames are queued from hand-written strings, a monitor checks
// every offered char against the queue head and pops on transfer.
module tb_stopwatch_lcd_formatter;

  logic        clk_1k = 1'b0;
  logic        rst_n, stopwatch_sw, sw_update_toggle, lap_valid, char_ready;
  logic [1:0]  sw_lcd_mode;
  logic [23:0] cur_bcd, lap_bcd, int_bcd, best_bcd, avg_bcd;
  logic        char_valid, char_row, busy, frame_done;
  logic [7:0]  char_data;
  logic [3:0]  char_col;

  typedef struct packed {
    logic [7:0] data;
    logic       row;
    logic [3:0] col;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic exp_done = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_1k = ~clk_1k;

  stopwatch_lcd_formatter dut (
    .clk_1k           (clk_1k),
    .rst_n            (rst_n),
    .stopwatch_sw     (stopwatch_sw),
    .sw_lcd_mode      (sw_lcd_mode),
    .sw_update_toggle (sw_update_toggle),
    .lap_valid        (lap_valid),
    .cur_bcd          (cur_bcd),
    .lap_bcd          (lap_bcd),
    .int_bcd          (int_bcd),
    .best_bcd         (best_bcd),
    .avg_bcd          (avg_bcd),
    .char_ready       (char_ready),
    .char_valid       (char_valid),
    .char_data        (char_data),
    .char_row         (char_row),
    .char_col         (char_col),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  task automatic push_frame(input string r0, input string r1);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.data = (i < 16) ? r0[i % 16] : r1[i % 16];
      e.row  = (i >= 16);
      e.col  = 4'(i % 16);
      e.last = (i == 31);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk_1k);
    #2;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk_1k);
      if (frame_done) break;
      n++;
      if (n > 2000) begin
        fail_now(name, "frame_done never seen within 2000 cycles");
        break;
      end
    end
  endtask

  task automatic wait_char(input logic r, input logic [3:0] c, input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk_1k);
      if (char_valid && char_row == r && char_col == c) break;
      n++;
      if (n > 500) begin
        fail_now(name, "char position never offered within 500 cycles");
        break;
      end
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, " valid"}, 32'(char_valid), 32'd0);
    chk({name, " data"},  32'(char_data),  32'h20);
    chk({name, " row"},   32'(char_row),   32'd0);
    chk({name, " col"},   32'(char_col),   32'd0);
    chk({name, " busy"},  32'(busy),       32'd0);
    chk({name, " done"},  32'(frame_done), 32'd0);
  endtask

  // Monitor: every offered char must equal the queue head; a popped last char predicts frame_done.
  always @(negedge clk_1k) begin
    if (rst_n === 1'b1) begin
      if (exp_done || frame_done) chk("frame_done pulse", 32'(frame_done), 32'(exp_done));
      exp_done = 1'b0;
      if (char_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected char", $sformatf("got 0x%0h at row %0d col %0d, none expected",
                   char_data, char_row, char_col));
        end else begin
          mon_e = exp_q[0];
          chk($sformatf("char r%0d c%0d", mon_e.row, mon_e.col),
              32'({char_row, char_col, char_data}), 32'({mon_e.row, mon_e.col, mon_e.data}));
          if (char_ready) begin
            void'(exp_q.pop_front());
            exp_done = mon_e.last;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stopwatch_sw = 1'b0; sw_update_toggle = 1'b0; lap_valid = 1'b0;
    char_ready = 1'b1; sw_lcd_mode = 2'd0;
    cur_bcd = 24'h012345; lap_bcd = 24'h000000; int_bcd = 24'h000000;
    best_bcd = 24'h000000; avg_bcd = 24'h000000;
    repeat (3) step();
    @(negedge clk_1k);
    check_reset("reset");
    step();
    rst_n = 1'b1;
    step();

    // 1: RUN frame on stopwatch enable, latency and trailing idle.
    push_frame("CUR   01:23.45  ", "LAP   --:--.--  ");
    stopwatch_sw = 1'b1;
    @(negedge clk_1k);
    @(negedge clk_1k);
    chk("t1 load valid", 32'(char_valid), 32'd0);
    chk("t1 load busy", 32'(busy), 32'd1);
    @(negedge clk_1k);
    chk("t1 first valid", 32'(char_valid), 32'd1);
    wait_done("t1 done");
    chk("t1 done valid", 32'(char_valid), 32'd0);
    @(negedge clk_1k);
    chk("t1 idle busy", 32'(busy), 32'd0);
    chk("t1 idle valid", 32'(char_valid), 32'd0);
    step();

    // 2: same frame with a 5-cycle stall at idx 7, then random ready.
    push_frame("CUR   01:23.45  ", "LAP   --:--.--  ");
    sw_update_toggle = ~sw_update_toggle;
    wait_char(1'b0, 4'd6, "t2 reach idx6");
    step();
    char_ready = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 3000; i++) begin
      char_ready = 1'($urandom_range(0, 1));
      @(negedge clk_1k);
      if (frame_done) break;
      if (i == 2999) fail_now("t2 done", "frame_done never seen under random ready");
      step();
    end
    step();
    char_ready = 1'b1;
    chk("t2 queue drained", 32'(exp_q.size()), 32'd0);
    step();

    // 3: STAT frame; inputs changed after LOAD must not leak into the frame.
    sw_lcd_mode = 2'd2; lap_valid = 1'b1; best_bcd = 24'h000299; avg_bcd = 24'h000300;
    push_frame("BEST  00:02.99  ", "AVG   00:03.00  ");
    sw_update_toggle = ~sw_update_toggle;
    wait_char(1'b0, 4'd0, "t3 first char");
    step();
    best_bcd = 24'h595959; avg_bcd = 24'h111111; sw_lcd_mode = 2'd0; lap_valid = 1'b0;
    wait_done("t3 done");
    step();

    // 4: three toggles during a frame coalesce into exactly one extra frame.
    sw_lcd_mode = 2'd1; lap_valid = 1'b1; lap_bcd = 24'h001000; int_bcd = 24'h000550;
    push_frame("LAP   00:10.00  ", "INT   00:05.50  ");
    push_frame("LAP   00:10.00  ", "INT   00:05.50  ");
    sw_update_toggle = ~sw_update_toggle;
    wait_char(1'b0, 4'd3, "t4 reach idx3");
    step();
    sw_update_toggle = ~sw_update_toggle;
    repeat (2) step();
    sw_update_toggle = ~sw_update_toggle;
    repeat (2) step();
    sw_update_toggle = ~sw_update_toggle;
    wait_done("t4 first done");
    @(negedge clk_1k);
    chk("t4 reload busy", 32'(busy), 32'd1);
    chk("t4 reload valid", 32'(char_valid), 32'd0);
    wait_done("t4 second done");
    repeat (20) @(negedge clk_1k);
    chk("t4 idle busy", 32'(busy), 32'd0);
    chk("t4 queue drained", 32'(exp_q.size()), 32'd0);
    step();

    // 5: non-decimal centisecond digit renders as '?'.
    sw_lcd_mode = 2'd0; lap_valid = 1'b0; cur_bcd = 24'h01234A;
    push_frame("CUR   01:23.4?  ", "LAP   --:--.--  ");
    sw_update_toggle = ~sw_update_toggle;
    wait_done("t5 done");
    step();

    // 6a: disable while char 10 is stalled: held until accepted, then idle, no frame_done.
    cur_bcd = 24'h012345;
    push_frame("CUR   01:23.45  ", "LAP   --:--.--  ");
    sw_update_toggle = ~sw_update_toggle;
    wait_char(1'b0, 4'd9, "t6 reach idx9");
    step();
    char_ready = 1'b0;
    stopwatch_sw = 1'b0;
    repeat (3) step();
    char_ready = 1'b1;
    @(negedge clk_1k);
    @(negedge clk_1k);
    chk("t6 abort valid", 32'(char_valid), 32'd0);
    chk("t6 abort busy", 32'(busy), 32'd0);
    chk("t6 abort done", 32'(frame_done), 32'd0);
    chk("t6 remaining chars", 32'(exp_q.size()), 32'd21);
    repeat (5) @(negedge clk_1k);
    chk("t6 still idle", 32'(char_valid), 32'd0);
    exp_q.delete();
    step();

    // 6b: reset in the middle of a frame.
    push_frame("CUR   01:23.45  ", "LAP   --:--.--  ");
    stopwatch_sw = 1'b1;
    wait_char(1'b0, 4'd4, "t6 reach idx4");
    step();
    rst_n = 1'b0;
    stopwatch_sw = 1'b0;
    @(posedge clk_1k);
    @(negedge clk_1k);
    check_reset("mid-frame reset");
    exp_q.delete();
    exp_done = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
